// File: rtl/rr_sel8_4x1.sv
// Round-robin 4-to-1 selector with a one-entry registered output stage (8-bit data).
// Optional transfer counter on port xfer_cnt is built only when RR_XFER_CNT_EN is defined.

module mux8_4x1 (
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  input  logic [7:0] d3,
  input  logic [1:0] s,
  output logic [7:0] y
);

  always_comb begin
    unique case (s)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

module rr_sel8_4x1 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [3:0] in_valid,
  output logic [3:0] in_ready,
  input  logic       out_ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic [1:0] sel
`ifdef RR_XFER_CNT_EN
  ,
  output logic [7:0] xfer_cnt
`endif
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] out_q, out_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;

  logic [3:0] rot;
  logic [1:0] off;
  logic [1:0] grant;
  logic       any_vld;
  logic       load;
  logic [7:0] mux_y;

`ifdef RR_XFER_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  // Rotate requests so that bit 0 is the channel at ptr, then pick the first one.
  always_comb begin
    unique case (ptr_q)
      2'd0:    rot = in_valid;
      2'd1:    rot = {in_valid[0],   in_valid[3:1]};
      2'd2:    rot = {in_valid[1:0], in_valid[3:2]};
      default: rot = {in_valid[2:0], in_valid[3]};
    endcase
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else             off = 2'd3;
    grant   = ptr_q + off;
    any_vld = |in_valid;
    load    = ((state_q == S_EMPTY) || out_ready) && any_vld;
  end

  mux8_4x1 u_mux (
    .d0 (in0),
    .d1 (in1),
    .d2 (in2),
    .d3 (in3),
    .s  (grant),
    .y  (mux_y)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      out_q   <= 8'h00;
      sel_q   <= 2'b00;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      state_d = S_FULL;
      out_d   = mux_y;
      sel_d   = grant;
      ptr_d   = grant + 2'd1;
    end else if ((state_q == S_FULL) && out_ready) begin
      state_d = S_EMPTY;
    end
  end

  // Outputs; in_ready is forced low while reset is held since load may look true then.
  always_comb begin
    in_ready  = 4'b0000;
    if (load && !rst) in_ready[grant] = 1'b1;
    out_valid = (state_q == S_FULL);
    out       = out_q;
    sel       = sel_q;
  end

`ifdef RR_XFER_CNT_EN
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == S_FULL) && out_ready) cnt_d = sat_inc8(cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'h00;
    else     cnt_q <= cnt_d;
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rr_sel8_4x1.sv
// Scoreboard bench for rr_sel8_4x1: a reference arbiter model predicts grants and
// queues the expected out/sel per accepted input, compared after the capturing edge.
module tb_rr_sel8_4x1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic       out_ready;
  logic [7:0] out;
  logic       out_valid;
  logic [1:0] sel;
`ifdef RR_XFER_CNT_EN
  logic [7:0] xfer_cnt;
`endif

  always #5 clk = ~clk;

  rr_sel8_4x1 dut (
    .clk       (clk),
    .rst       (rst),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out       (out),
    .out_valid (out_valid),
    .sel       (sel)
`ifdef RR_XFER_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] d;
    logic [1:0] s;
  } exp_t;
  exp_t sbq[$];

  logic [1:0] m_ptr;
  bit         m_full;
  logic [7:0] m_out;
  logic [1:0] m_sel;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] mgrant(input logic [1:0] p, input logic [3:0] v);
    logic [1:0] idx;
    for (int k = 0; k < 4; k++) begin
      idx = p + k[1:0];
      if (v[idx]) return idx;
    end
    return p;
  endfunction

  function automatic logic [7:0] data_of(input logic [1:0] i);
    case (i)
      2'd0:    return in0;
      2'd1:    return in1;
      2'd2:    return in2;
      default: return in3;
    endcase
  endfunction

  // One clock: inputs already driven; predict, check in_ready, then check the registered result.
  task automatic cycle();
    logic       mload;
    logic [1:0] g;
    exp_t       e;
    @(negedge clk);
    mload = (!m_full || out_ready) && (in_valid != 4'b0000);
    g     = mgrant(m_ptr, in_valid);
    chk("in_ready", in_ready, mload ? (4'b0001 << g) : 4'b0000);
    if (mload) begin
      e.d = data_of(g);
      e.s = g;
      sbq.push_back(e);
    end
    if (m_full && out_ready && m_cnt < 255) m_cnt++;
    @(posedge clk);
    #1;
    if (mload) begin
      m_ptr  = g + 2'd1;
      m_full = 1'b1;
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        e     = sbq.pop_front();
        m_out = e.d;
        m_sel = e.s;
      end
    end else if (m_full && out_ready) begin
      m_full = 1'b0;
    end
    chk("out", out, m_out);
    chk("sel", sel, m_sel);
    chk("out_valid", out_valid, m_full);
`ifdef RR_XFER_CNT_EN
    chk("xfer_cnt", xfer_cnt, m_cnt);
`endif
  endtask

  // Async reset pulse between edges; returns just after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out", out, 8'h00);
    chk("rst_sel", sel, 2'b00);
    chk("rst_in_ready", in_ready, 4'b0000);
`ifdef RR_XFER_CNT_EN
    chk("rst_xfer_cnt", xfer_cnt, 8'h00);
`endif
    m_ptr  = 2'd0;
    m_full = 1'b0;
    m_out  = 8'h00;
    m_sel  = 2'b00;
    m_cnt  = 0;
    sbq.delete();
    in_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp30 [5];
  logic [1:0] exp31 [3];

  initial begin
    rst       = 1'b1;
    in0       = 8'h00;
    in1       = 8'h00;
    in2       = 8'h00;
    in3       = 8'h00;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    #1;
    do_reset();

    // Full contention, continuous drain.
    exp30 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    in0 = 8'hA0; in1 = 8'hA1; in2 = 8'hA2; in3 = 8'hA3;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("r30_sel", sel, exp30[i]);
      chk("r30_out", out, 8'hA0 + exp30[i]);
    end

    // Sparse requests alternate between channels 1 and 3.
    in_valid = 4'b1111;
    do_reset();
    exp31 = '{2'd1, 2'd3, 2'd1};
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("r31_sel", sel, exp31[i]);
    end

    // Back-pressure hold, then release loads in the same cycle.
    in0 = 8'h5C;
    in_valid = 4'b0001;
    cycle();
    chk("hold_load", out, 8'h5C);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("hold_out", out, 8'h5C);
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 4'b0000;
    cycle();
    chk("drain_valid", out_valid, 1'b0);
    cycle();

    // Reset while FULL, then lowest valid channel wins.
    in_valid = 4'b1111;
    cycle();
    cycle();
    do_reset();
    in_valid = 4'b1100;
    cycle();
    chk("post_rst_sel", sel, 2'd2);

    // Randomised traffic.
    for (int i = 0; i < 200; i++) begin
      in0       = 8'($urandom);
      in1       = 8'($urandom);
      in2       = 8'($urandom);
      in3       = 8'($urandom);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

`ifdef RR_XFER_CNT_EN
    do_reset();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) cycle();
    chk("cnt_sat", xfer_cnt, 8'hFF);
    cycle();
    chk("cnt_hold", xfer_cnt, 8'hFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
